// File: rtl/health_pkg.sv
// health_pkg: shared states, hit sources and default tuning constants for the health controller
package health_pkg;
   typedef enum logic [1:0] {ALIVE, INVULN, DEAD, RESPAWN} health_state_t;
   typedef enum logic [1:0] {SRC_NONE = 2'b00, SRC_ENEMY = 2'b01, SRC_MET = 2'b10, SRC_SHOT = 2'b11} hit_src_t;
   localparam int MAX_HEALTH_DEF = 4;
   localparam int HW_DEF = 3;
   localparam int DMG_ENEMY_DEF = 1;
   localparam int DMG_MET_DEF = 1;
   localparam int DMG_SHOT_DEF = 2;
   localparam int HEAL_AMT_DEF = 1;
   localparam int IFRAMES_DEF = 60;
   localparam int BLINK_DIV_DEF = 4;
   localparam logic [15:0] RESPAWN_KEY_DEF = 16'h0010;
endpackage

// File: rtl/health_ctrl_if.sv
// health_ctrl_if: collision/keyboard inputs and HUD/sprite outputs of the health controller
interface health_ctrl_if #(parameter int HW = 3);
   logic          enemycol;
   logic          met1_col;
   logic          shot_col;
   logic          heal_pickup;
   logic [15:0]   keycode;
   logic [HW-1:0] curr_health;
   logic          invuln;
   logic          blink;
   logic          dead;
   logic          hit_pulse;
   logic [1:0]    hit_src;
   modport master (
      output enemycol, met1_col, shot_col, heal_pickup, keycode,
      input  curr_health, invuln, blink, dead, hit_pulse, hit_src
   );
   modport slave (
      input  enemycol, met1_col, shot_col, heal_pickup, keycode,
      output curr_health, invuln, blink, dead, hit_pulse, hit_src
   );
endinterface

// File: rtl/health_ctrl_frame_timer.sv
// frame_timer: loadable frame down-counter with zero flag and a blink divider
module frame_timer #(
   parameter int W   = 6,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   input  logic         blink_en,
   output logic         zero,
   output logic         blink
);
   localparam int DW = $clog2(DIV + 1);
   localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
   logic [W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0] div_q, div_d;
   logic          blink_q, blink_d, wrap;
   // next count; divider and blink clear whenever blinking is not enabled
   always_comb begin
      wrap    = div_q == DLAST;
      cnt_d   = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      div_d   = (!blink_en || wrap) ? '0 : div_q + 1'b1;
      blink_d = blink_en && (blink_q ^ wrap);
   end
   // counter, divider and blink registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         div_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         blink_q <= blink_d;
      end
   end
   assign zero  = cnt_q == '0;
   assign blink = blink_q;
endmodule

// File: rtl/health_ctrl.sv
// health_ctrl: prioritised damage, edge-detected healing, invincibility, death and respawn
module health_ctrl import health_pkg::*; #(
   parameter int          MAX_HEALTH  = MAX_HEALTH_DEF,
   parameter int          HW          = HW_DEF,
   parameter int          DMG_ENEMY   = DMG_ENEMY_DEF,
   parameter int          DMG_MET     = DMG_MET_DEF,
   parameter int          DMG_SHOT    = DMG_SHOT_DEF,
   parameter int          HEAL_AMT    = HEAL_AMT_DEF,
   parameter int          IFRAMES     = IFRAMES_DEF,
   parameter int          BLINK_DIV   = BLINK_DIV_DEF,
   parameter logic [15:0] RESPAWN_KEY = RESPAWN_KEY_DEF
) (
   input  logic          frame_clk,
   input  logic          reset,
   health_ctrl_if.slave  bus
);
   localparam int HW1 = HW + 1;
   localparam int TW  = $clog2(IFRAMES + 1);
   localparam logic [HW:0]   MAXV  = HW1'(MAX_HEALTH);
   localparam logic [HW:0]   DMG_E = HW1'(DMG_ENEMY);
   localparam logic [HW:0]   DMG_M = HW1'(DMG_MET);
   localparam logic [HW:0]   DMG_S = HW1'(DMG_SHOT);
   localparam logic [HW:0]   HEALV = HW1'(HEAL_AMT);
   localparam logic [TW-1:0] ILOAD = TW'(IFRAMES - 1);
   health_state_t state_q, state_d;
   hit_src_t      hit_src_q, hit_src_d, src;
   logic [HW-1:0] health_q, health_d;
   logic          hit_pulse_q, hit_pulse_d, heal_prev_q;
   logic          any_dmg, heal_edge, tmr_load, tmr_zero, blink;
   logic [HW:0]   dmg, heal, h_ext, dsum, hsum, dsat, hsat;
   // fixed-priority damage select and saturating health arithmetic at HW+1 bits
   always_comb begin
      any_dmg   = bus.enemycol | bus.met1_col | bus.shot_col;
      src       = bus.enemycol ? SRC_ENEMY : bus.met1_col ? SRC_MET : SRC_SHOT;
      dmg       = bus.enemycol ? DMG_E : bus.met1_col ? DMG_M : DMG_S;
      heal_edge = bus.heal_pickup & ~heal_prev_q;
      heal      = heal_edge ? HEALV : '0;
      h_ext     = {1'b0, health_q};
      dsum      = h_ext - dmg + heal;
      hsum      = h_ext + heal;
      dsat      = dsum > MAXV ? MAXV : dsum;
      hsat      = hsum > MAXV ? MAXV : hsum;
   end
   // next state, health, hit reporting and timer load
   always_comb begin
      state_d     = state_q;
      health_d    = health_q;
      hit_pulse_d = 1'b0;
      hit_src_d   = hit_src_q;
      tmr_load    = 1'b0;
      case (state_q)
         ALIVE: begin
            if (any_dmg) begin
               hit_pulse_d = 1'b1;
               hit_src_d   = src;
               if (h_ext <= dmg) begin
                  health_d = '0;
                  state_d  = DEAD;
               end else begin
                  health_d = dsat[HW-1:0];
                  tmr_load = 1'b1;
                  state_d  = INVULN;
               end
            end else if (heal_edge) begin
               health_d = hsat[HW-1:0];
            end
         end
         INVULN: begin
            health_d = hsat[HW-1:0];
            state_d  = tmr_zero ? ALIVE : INVULN;
         end
         DEAD: state_d = (bus.keycode == RESPAWN_KEY) ? RESPAWN : DEAD;
         RESPAWN: begin
            health_d = MAXV[HW-1:0];
            tmr_load = 1'b1;
            state_d  = INVULN;
         end
      endcase
   end
   // controller registers
   always_ff @(posedge frame_clk) begin
      if (reset) begin
         state_q     <= ALIVE;
         health_q    <= MAXV[HW-1:0];
         hit_pulse_q <= 1'b0;
         hit_src_q   <= SRC_NONE;
         heal_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         health_q    <= health_d;
         hit_pulse_q <= hit_pulse_d;
         hit_src_q   <= hit_src_d;
         heal_prev_q <= bus.heal_pickup;
      end
   end
   frame_timer #(.W(TW), .DIV(BLINK_DIV)) u_timer (
      .clk      (frame_clk),
      .rst      (reset),
      .load     (tmr_load),
      .load_val (ILOAD),
      .dec      (state_q == INVULN),
      .blink_en (state_q == INVULN && state_d == INVULN),
      .zero     (tmr_zero),
      .blink    (blink)
   );
   assign bus.curr_health = health_q;
   assign bus.invuln      = state_q == INVULN;
   assign bus.dead        = state_q == DEAD;
   assign bus.blink       = blink;
   assign bus.hit_pulse   = hit_pulse_q;
   assign bus.hit_src     = hit_src_q;
endmodule

// File: tb/tb_health_ctrl.sv
// tb_health_ctrl: directed checks of damage priority, invincibility, heal, death, respawn and reset
module tb_health_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   health_ctrl_if #(.HW(3)) bus ();
   health_ctrl dut (.frame_clk(clk), .reset(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wait_alive(output int n);
      n = 0;
      while (bus.invuln && n < 100) begin
         tick();
         n++;
      end
   endtask
   task automatic chk_out(input string tag, input int h, input int inv, input int bl, input int dd, input int hp, input int src);
      if (h >= 0) chk({tag, ".health"}, int'(bus.curr_health), h);
      chk({tag, ".invuln"}, int'(bus.invuln), inv);
      chk({tag, ".blink"}, int'(bus.blink), bl);
      chk({tag, ".dead"}, int'(bus.dead), dd);
      chk({tag, ".hit_pulse"}, int'(bus.hit_pulse), hp);
      chk({tag, ".hit_src"}, int'(bus.hit_src), src);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n, stuck;
      bus.enemycol = 0; bus.met1_col = 0; bus.shot_col = 0; bus.heal_pickup = 0; bus.keycode = 16'h0000;
      tick(2);
      chk_out("reset", 4, 0, 0, 0, 0, 0);
      rst = 1'b0;
      bus.enemycol = 1; tick(); bus.enemycol = 0;
      chk_out("hit1", 3, 1, 0, 0, 1, 1);
      tick();
      chk_out("hit1_c2", 3, 1, 0, 0, 0, 1);
      tick(2); chk("blink_c4", int'(bus.blink), 0);
      tick();  chk("blink_c5", int'(bus.blink), 1);
      tick(4); chk("blink_c9", int'(bus.blink), 0);
      wait_alive(n); chk("iframes1", n, 52);
      chk_out("alive1", 3, 0, 0, 0, 0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      bus.enemycol = 1; bus.met1_col = 1; bus.shot_col = 1; tick();
      chk_out("prio", 3, 1, 0, 0, 1, 1);
      stuck = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.curr_health != 3 || bus.hit_pulse) stuck++;
      end
      chk("prio_hold", stuck, 0);
      chk_out("prio_exit", 3, 0, 0, 0, 0, 1);
      tick();
      chk_out("prio_rehit", 2, 1, 0, 0, 1, 1);
      bus.enemycol = 0; bus.met1_col = 0; bus.shot_col = 0;
      tick(4);
      chk_out("pre_rst", 2, 1, 1, 0, 0, 1);
      rst = 1'b1; tick();
      chk_out("rst_mid", 4, 0, 0, 0, 0, 0);
      rst = 1'b0; tick();
      chk_out("rst_after", 4, 0, 0, 0, 0, 0);
      bus.shot_col = 1; tick(); bus.shot_col = 0;
      chk_out("shot", 2, 1, 0, 0, 1, 3);
      wait_alive(n); chk("iframes2", n, 60);
      bus.shot_col = 1; tick(); bus.shot_col = 0;
      chk_out("death", 0, 0, 0, 1, 1, 3);
      bus.heal_pickup = 1; bus.enemycol = 1; tick(3);
      chk_out("dead_ign", 0, 0, 0, 1, 0, 3);
      bus.heal_pickup = 0; bus.enemycol = 0;
      bus.keycode = 16'h0010; tick();
      chk_out("respawn", -1, 0, 0, 0, 0, 3);
      tick();
      chk_out("spawned", 4, 1, 0, 0, 0, 3);
      wait_alive(n); chk("iframes3", n, 60);
      chk_out("alive3", 4, 0, 0, 0, 0, 3);
      bus.keycode = 16'h0000;
      bus.met1_col = 1; tick(); bus.met1_col = 0;
      chk_out("met", 3, 1, 0, 0, 1, 2);
      bus.heal_pickup = 1; tick();
      chk("heal_once", int'(bus.curr_health), 4);
      tick(9);
      chk("heal_held", int'(bus.curr_health), 4);
      bus.heal_pickup = 0; tick();
      bus.heal_pickup = 1; tick();
      chk("heal_sat", int'(bus.curr_health), 4);
      bus.heal_pickup = 0;
      wait_alive(n); chk("iframes4", n, 48);
      bus.shot_col = 1; tick(); bus.shot_col = 0;
      chk("to2", int'(bus.curr_health), 2);
      wait_alive(n); chk("iframes5", n, 60);
      bus.enemycol = 1; tick(); bus.enemycol = 0;
      chk("to1", int'(bus.curr_health), 1);
      wait_alive(n); chk("iframes6", n, 60);
      bus.enemycol = 1; bus.heal_pickup = 1; tick();
      bus.enemycol = 0; bus.heal_pickup = 0;
      chk_out("dead_heal", 0, 0, 0, 1, 1, 1);
      tick(2);
      chk_out("dead_stay", 0, 0, 0, 1, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/health_ctrl.md
Name: health_ctrl

Overview:
- Player-health controller: arbitrates damage sources (enemy, meteor, enemy shot) and heal pickups into one saturating health register.
- Enforces post-hit invincibility frames, death, and keyboard respawn.
- Drives the HUD health bar, sprite blink and game-over logic.
- Clocked once per video frame, so one hit at most per frame.

Parameters:
- MAX_HEALTH, 4, full-health value; also the respawn value.
- HW, 3, width of health count; must satisfy 2^HW > MAX_HEALTH.
- DMG_ENEMY, 1, damage for an enemy contact.
- DMG_MET, 1, damage for a meteor contact.
- DMG_SHOT, 2, damage for an enemy-projectile contact.
- HEAL_AMT, 1, health restored per pickup.
- IFRAMES, 60, invincibility length in frames; must be ≥1.
- BLINK_DIV, 4, frames per blink half-period.
- RESPAWN_KEY, 16'h0010, keycode value that triggers respawn.

Ports:
- frame_clk, in, 1, frame-rate clock; single clock domain.
- reset, in, 1, synchronous, active-high.
- enemycol, in, 1, level: player overlaps enemy.
- met1_col, in, 1, level: player overlaps meteor.
- shot_col, in, 1, level: player overlaps enemy projectile.
- heal_pickup, in, 1, level: player overlaps health item.
- keycode, in, 16, current keyboard code.
- curr_health, out, HW, registered health.
- invuln, out, 1, high in INVULN.
- blink, out, 1, sprite hide strobe during invincibility.
- dead, out, 1, high in DEAD.
- hit_pulse, out, 1, one-cycle pulse when damage is applied.
- hit_src, out, 2, source of last applied hit: 00 none, 01 enemy, 10 meteor, 11 shot. Held until the next hit or reset.

Behaviour:
- Reset (synchronous, active-high, frame_clk): state ALIVE, curr_health=MAX_HEALTH, invuln=0, blink=0, dead=0, hit_pulse=0, hit_src=00, timer=0, heal_prev=0. Reset overrides everything, including mid-INVULN and DEAD.
- Latency: inputs sampled at edge n; every output reflects them after edge n. All outputs are registered.
- Damage arbitration: fixed priority enemycol > met1_col > shot_col.
  - At most one damage event is applied per cycle; lower-priority simultaneous requests are dropped, not queued.
  - dmg = the selected source's DMG_*.
- Heal: edge-detected (heal_pickup & ~heal_prev), so a held pickup counts once. heal_prev updates every cycle in all states.
- Arithmetic: do health math at HW+1 bits.
  - Damage saturates at 0.
  - Heal saturates at MAX_HEALTH.
- State ALIVE:
  - If any damage request: hit_pulse=1, hit_src=selected source.
    - If health ≤ dmg: health←0, go DEAD; heal in the same cycle is ignored.
    - Otherwise: health←health−dmg+heal (saturated), timer←IFRAMES−1, go INVULN.
  - Else if heal edge: health←min(health+HEAL_AMT, MAX_HEALTH).
- State INVULN:
  - All damage requests are ignored; hit_pulse stays 0.
  - Heal edges are applied.
  - timer decrements each cycle; when timer==0, go ALIVE.
  - A damage request on the exit cycle is ignored; one on the following cycle is applied.
  - Net effect: exactly IFRAMES cycles of invuln=1.
- State DEAD:
  - dead=1, curr_health=0; damage and heal are ignored.
  - keycode==RESPAWN_KEY → RESPAWN.
- State RESPAWN (one cycle):
  - health←MAX_HEALTH, timer←IFRAMES−1, go INVULN (spawn protection).
  - invuln=0 and dead=0 during this cycle.
  - A held respawn key has no further effect once out of DEAD.
- Blink:
  - Divider counts frames while in INVULN; blink toggles every BLINK_DIV frames.
  - blink starts at 0 on INVULN entry.
  - blink is forced to 0 and the divider cleared in every other state.
- hit_pulse is high for exactly the cycle after the hit is sampled, and is never high in consecutive cycles.

Decomposition:
- Package health_pkg holds:
  - enum health_state_t {ALIVE, INVULN, DEAD, RESPAWN};
  - enum hit_src_t {SRC_NONE=2'b00, SRC_ENEMY=2'b01, SRC_MET=2'b10, SRC_SHOT=2'b11};
  - default damage, heal and key constants.
- Sub-module frame_timer: loadable down-counter with a zero flag and the blink divider. It is shared with other timed game effects.
- Priority select, saturating health math and FSM live in health_ctrl.

Test Plan:
- Reset, then enemycol=1 for 1 cycle → hit_pulse=1, hit_src=01, curr_health=3, invuln=1 for exactly 60 cycles, then ALIVE.
- enemycol, met1_col, shot_col all asserted the same cycle at health 4 → only enemy applied: health=3, hit_src=01. The same request held through INVULN causes no further loss until cycle 61, then health=2.
- health=2, shot_col=1 → health=0, dead=1, hit_src=11. Then heal_pickup and enemycol are asserted → no change. keycode=16'h0010 → RESPAWN for 1 cycle, then health=4, invuln=1 for 60 cycles.
- health=3 in INVULN, heal_pickup held 10 cycles → health=4 once, no overshoot. A second pickup edge at health 4 keeps health at 4.
- health=1 in ALIVE, enemycol and a heal edge in the same cycle → DEAD, health=0, heal dropped.
- Assert reset mid-INVULN with health=2, blink=1 → next cycle health=4, invuln=0, blink=0, hit_src=00, state ALIVE.
